// File: rtl/nes_input_pkg.sv
// Shared definitions for the NES joypad input path.
//   - Button bit positions inside an 8-bit pad state (1 = pressed).
//   - Four Score signature bytes appended after the pad data on each port.
//   - Serial stream width per controller port.
//   - pad_state_t: one controller's 8 button bits.
package nes_input_pkg;

  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

  localparam logic [7:0] FS_SIG_PORT0 = 8'h08;
  localparam logic [7:0] FS_SIG_PORT1 = 8'h04;

  localparam int STREAM_W = 24;

  typedef logic [7:0] pad_state_t;

endpackage

// File: rtl/nes_pad_shifter.sv
// One controller port: 24-bit serial frame, saturating bit counter and
// falling-edge detect on the port's read clock.
// Ports:
//   clk, reset_n  - clock, asynchronous active-low reset
//   clear         - synchronous clear (same effect as reset)
//   frame         - frame loaded while strobe is high (shifted out LSB first)
//   strobe        - latch; reloads frame every cycle it is high
//   clk_bit       - this port's read clock; a falling edge advances the stream
//   fill_bit      - value shifted in at the top of the register
//   data_out      - current serial bit (registered)
module nes_pad_shifter
  import nes_input_pkg::*;
(
  input  logic                clk,
  input  logic                reset_n,
  input  logic                clear,
  input  logic [STREAM_W-1:0] frame,
  input  logic                strobe,
  input  logic                clk_bit,
  input  logic                fill_bit,
  output logic                data_out
);

  localparam logic [4:0] CNT_MAX = 5'(STREAM_W);

  logic [STREAM_W-1:0] shift_q, shift_d;
  logic [4:0]          cnt_q, cnt_d;
  logic                last_clk_q, last_clk_d;
  logic                fall;

  assign fall = ~clk_bit & last_clk_q;

  always_comb begin
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    last_clk_d = clk_bit;
    if (clear) begin
      shift_d    = '0;
      cnt_d      = '0;
      last_clk_d = 1'b0;
    end else if (strobe) begin
      // Strobe beats a coincident clock edge: the frame restarts at bit 0.
      shift_d = frame;
      cnt_d   = '0;
    end else if (fall) begin
      // Past the end of the frame the register keeps shifting fill_bit.
      shift_d = {fill_bit, shift_q[STREAM_W-1:1]};
      if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + 5'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shift_q    <= '0;
      cnt_q      <= '0;
      last_clk_q <= 1'b0;
    end else begin
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      last_clk_q <= last_clk_d;
    end
  end

  assign data_out = shift_q[0];

endmodule

// File: rtl/nes_joypad_serializer.sv
// Serialises NUM_PADS joypad states onto the two NES controller data lines
// ($4016 D0 on port 0, $4017 D0 on port 1), with Four Score multiplexing.
// Optional turbo is compiled in with `define NES_JOY_TURBO_EN.
// Ports:
//   clk, reset_n   - core clock, asynchronous active-low reset
//   clear          - synchronous clear from reset_nes
//   joy_in         - pad p in [p*8+7:p*8], 1 = pressed
//   fourscore_en   - 4-player mode request (only honoured when NUM_PADS==4)
//   joypad_strobe  - latch from the core
//   joypad_clock   - per-port read clock, falling edge advances
//   joypad_data    - serial bit per port
//   turbo_in       - (turbo only) {B,A} turbo request per pad
//   frame_tick     - (turbo only) one pulse per video frame
module nes_joypad_serializer
  import nes_input_pkg::*;
#(
  parameter int   NUM_PADS     = 2,
  parameter logic FILL_BIT     = 1'b1,
  parameter int   TURBO_PERIOD = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clear,
  input  logic [NUM_PADS*8-1:0] joy_in,
  input  logic                  fourscore_en,
  input  logic                  joypad_strobe,
  input  logic [1:0]            joypad_clock,
  output logic [1:0]            joypad_data
`ifdef NES_JOY_TURBO_EN
  ,
  input  logic [NUM_PADS*2-1:0] turbo_in,
  input  logic                  frame_tick
`endif
);

  generate
    if ((NUM_PADS != 2 && NUM_PADS != 4) || TURBO_PERIOD < 1 || TURBO_PERIOD > 15) begin : g_bad_param
      $error("nes_joypad_serializer: illegal NUM_PADS or TURBO_PERIOD");
    end
  endgenerate

`ifdef NES_JOY_TURBO_EN
  localparam logic [3:0] TURBO_LAST = 4'(TURBO_PERIOD - 1);

  logic [3:0] frame_cnt_q, frame_cnt_d;
  logic       turbo_phase_q, turbo_phase_d;

  always_comb begin
    frame_cnt_d   = frame_cnt_q;
    turbo_phase_d = turbo_phase_q;
    if (clear) begin
      frame_cnt_d   = '0;
      turbo_phase_d = 1'b0;
    end else if (frame_tick) begin
      if (frame_cnt_q == TURBO_LAST) begin
        frame_cnt_d   = '0;
        turbo_phase_d = ~turbo_phase_q;
      end else begin
        frame_cnt_d = frame_cnt_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_cnt_q   <= '0;
      turbo_phase_q <= 1'b0;
    end else begin
      frame_cnt_q   <= frame_cnt_d;
      turbo_phase_q <= turbo_phase_d;
    end
  end
`endif

  // Absent pads read as all-released so the 2-pad build needs no special case.
  pad_state_t pad_eff [4];

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_pad
      if (gi < NUM_PADS) begin : g_present
`ifdef NES_JOY_TURBO_EN
        pad_state_t turbo_mask;
        always_comb begin
          turbo_mask        = '0;
          turbo_mask[BTN_A] = turbo_in[gi*2]   & turbo_phase_q;
          turbo_mask[BTN_B] = turbo_in[gi*2+1] & turbo_phase_q;
        end
        assign pad_eff[gi] = joy_in[gi*8 +: 8] | turbo_mask;
`else
        assign pad_eff[gi] = joy_in[gi*8 +: 8];
`endif
      end else begin : g_absent
        assign pad_eff[gi] = '0;
      end
    end
  endgenerate

  // Frames are only captured on strobe, so a mid-stream change of
  // fourscore_en or turbo phase cannot alter a read in progress.
  logic                fs_active;
  logic [STREAM_W-1:0] frame [2];

  assign fs_active = (NUM_PADS == 4) && fourscore_en;
  assign frame[0]  = fs_active ? {FS_SIG_PORT0, pad_eff[2], pad_eff[0]}
                               : {{16{FILL_BIT}}, pad_eff[0]};
  assign frame[1]  = fs_active ? {FS_SIG_PORT1, pad_eff[3], pad_eff[1]}
                               : {{16{FILL_BIT}}, pad_eff[1]};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_port
      nes_pad_shifter u_shifter (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear    (clear),
        .frame    (frame[gi]),
        .strobe   (joypad_strobe),
        .clk_bit  (joypad_clock[gi]),
        .fill_bit (FILL_BIT),
        .data_out (joypad_data[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_nes_joypad_serializer.sv
// Directed bench for nes_joypad_serializer (4-pad build, FILL_BIT=1).
// Inputs change right after a falling clock edge; outputs are sampled there too.
module tb_nes_joypad_serializer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        clear;
  logic [31:0] joy_in;
  logic        fourscore_en;
  logic        joypad_strobe;
  logic [1:0]  joypad_clock;
  logic [1:0]  joypad_data;
`ifdef NES_JOY_TURBO_EN
  logic [7:0]  turbo_in;
  logic        frame_tick;
`endif

  always #5 clk = ~clk;

  nes_joypad_serializer #(
    .NUM_PADS     (4),
    .FILL_BIT     (1'b1),
    .TURBO_PERIOD (2)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .clear         (clear),
    .joy_in        (joy_in),
    .fourscore_en  (fourscore_en),
    .joypad_strobe (joypad_strobe),
    .joypad_clock  (joypad_clock),
    .joypad_data   (joypad_data)
`ifdef NES_JOY_TURBO_EN
    ,
    .turbo_in      (turbo_in),
    .frame_tick    (frame_tick)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] pads;       // {pad3, pad2, pad1, pad0}
    logic        fs;
    int          port;
    logic [23:0] exp_frame;  // hand-assembled stream for 'port'
    logic        other_bit;  // bit 0 of the other port's frame
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic latch();
    joypad_strobe = 1'b1;
    tick();
    joypad_strobe = 1'b0;
    tick();
  endtask

  task automatic fall_edge(input int port);
    joypad_clock[port] = 1'b0;
    tick();
    joypad_clock[port] = 1'b1;
    tick();
  endtask

  initial begin
    logic exp_bit;
    int   other;

    vecs[0] = '{32'h00FF3CA5, 1'b0, 0, 24'hFFFFA5, 1'b0};
    vecs[1] = '{32'h00FF3CA5, 1'b0, 1, 24'hFFFF3C, 1'b1};
    vecs[2] = '{32'h04030201, 1'b1, 1, 24'h040402, 1'b1};
    vecs[3] = '{32'h04030201, 1'b1, 0, 24'h080301, 1'b0};
    vecs[4] = '{32'h0FC03000, 1'b0, 1, 24'hFFFF30, 1'b0};
    vecs[5] = '{32'h0F3CFFC0, 1'b0, 0, 24'hFFFFC0, 1'b1};

    reset_n       = 1'b0;
    clear         = 1'b0;
    joy_in        = '0;
    fourscore_en  = 1'b0;
    joypad_strobe = 1'b0;
    joypad_clock  = 2'b11;
`ifdef NES_JOY_TURBO_EN
    turbo_in      = '0;
    frame_tick    = 1'b0;
`endif
    tick();
    tick();
    check("reset_state", 32'(joypad_data), 32'h0);
    reset_n = 1'b1;
    tick();
    check("after_release", 32'(joypad_data), 32'h0);
    $display("reset: data=%b", joypad_data);

    // Table: latch, then 25 falling edges, comparing both ports at every bit.
    for (int v = 0; v < 6; v++) begin
      joy_in       = vecs[v].pads;
      fourscore_en = vecs[v].fs;
      other        = 1 - vecs[v].port;
      latch();
      fourscore_en = ~vecs[v].fs;  // must not affect the stream in flight
      for (int b = 0; b < 26; b++) begin
        exp_bit = (b < 24) ? vecs[v].exp_frame[b] : 1'b1;
        check($sformatf("vec%0d_bit%0d", v, b), 32'(joypad_data[vecs[v].port]), 32'(exp_bit));
        check($sformatf("vec%0d_other%0d", v, b), 32'(joypad_data[other]), 32'(vecs[v].other_bit));
        if (b < 25) fall_edge(vecs[v].port);
      end
      $display("vec %0d: pads=%h fs=%b port=%0d frame=%h", v, vecs[v].pads, vecs[v].fs,
               vecs[v].port, vecs[v].exp_frame);
    end
    fourscore_en = 1'b0;

    // Asynchronous reset mid-stream.
    joy_in = 32'h0000FFA5;
    latch();
    fall_edge(0);
    fall_edge(0);
    check("rst_pre", 32'(joypad_data), 32'h3);
    #2 reset_n = 1'b0;
    #1 check("rst_async", 32'(joypad_data), 32'h0);
    tick();
    reset_n = 1'b1;
    tick();
    check("rst_released", 32'(joypad_data), 32'h0);
    fall_edge(0);
    check("rst_edge_no_frame", 32'(joypad_data), 32'h0);
    latch();
    check("rst_relatch", 32'(joypad_data), 32'h3);
    fall_edge(0);
    check("rst_relatch_bit1", 32'(joypad_data), 32'h2);
    $display("async reset mid-stream: data=%b", joypad_data);

    // Synchronous clear mid-stream.
    fall_edge(0);
    check("clr_pre", 32'(joypad_data), 32'h3);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clr_effect", 32'(joypad_data), 32'h0);
    tick();
    check("clr_hold", 32'(joypad_data), 32'h0);
    latch();
    check("clr_relatch", 32'(joypad_data), 32'h3);
    $display("clear mid-stream: data=%b", joypad_data);

    // Strobe held high: port 0 follows A live, clock edges ignored.
    joy_in        = 32'h0000FF00;
    joypad_strobe = 1'b1;
    tick();
    check("held_a0", 32'(joypad_data[0]), 32'h0);
    fall_edge(0);
    check("held_edge_a0", 32'(joypad_data[0]), 32'h0);
    joy_in[0] = 1'b1;
    #1 check("held_latency", 32'(joypad_data[0]), 32'h0);
    tick();
    check("held_follow1", 32'(joypad_data[0]), 32'h1);
    fall_edge(0);
    fall_edge(0);
    check("held_edges_a1", 32'(joypad_data[0]), 32'h1);
    joy_in[0] = 1'b0;
    tick();
    check("held_follow0", 32'(joypad_data[0]), 32'h0);
    joy_in[0] = 1'b1;
    tick();
    joypad_strobe = 1'b0;
    tick();
    check("held_release_bit0", 32'(joypad_data[0]), 32'h1);
    fall_edge(0);
    check("held_release_bit1", 32'(joypad_data[0]), 32'h0);
    $display("strobe held: data0=%b", joypad_data[0]);

    // Strobe and clock[0] falling edge in the same cycle at bit 5.
    joy_in = 32'h0000FFA5;
    latch();
    for (int k = 0; k < 5; k++) fall_edge(0);
    check("col_bit5", 32'(joypad_data[0]), 32'h1);
    joy_in[7:0]     = 8'h01;
    joypad_clock[0] = 1'b0;
    joypad_strobe   = 1'b1;
    tick();
    joypad_strobe   = 1'b0;
    joypad_clock[0] = 1'b1;
    tick();
    check("col_reload", 32'(joypad_data), 32'h3);
    fall_edge(0);
    check("col_next", 32'(joypad_data), 32'h2);
    $display("collision: data=%b", joypad_data);

`ifdef NES_JOY_TURBO_EN
    begin
      logic [5:0] turbo_exp;
      turbo_exp = 6'b001100;  // frame 0 in bit 0
      clear = 1'b1;
      tick();
      clear       = 1'b0;
      joy_in      = '0;
      turbo_in    = 8'h01;
      for (int f = 0; f < 6; f++) begin
        latch();
        check($sformatf("turbo_frame%0d", f), 32'(joypad_data[0]), 32'(turbo_exp[f]));
        $display("turbo frame %0d: A=%b", f, joypad_data[0]);
        frame_tick = 1'b1;
        tick();
        frame_tick = 1'b0;
        tick();
      end
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
